// File: rtl/sorter_pkg.sv
// Shared types and constants for the odd-even transposition sorter.
package sorter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        DONE
    } sort_state_t;

    localparam logic SORT_ASC  = 1'b0;
    localparam logic SORT_DESC = 1'b1;

    // Width needed to count the worst-case number of swaps, N*(N-1)/2.
    function automatic int calc_cw(input int n);
        return $clog2(n * (n - 1) / 2 + 1);
    endfunction

endpackage

// File: rtl/cmp_swap.sv
// Single compare-and-swap cell; orders one pair according to dir.
// With SORTER_INDEX_EN defined, an index tag travels with each element.
module cmp_swap
    import sorter_pkg::*;
#(
    parameter int W = 8
`ifdef SORTER_INDEX_EN
    ,
    parameter int TW = 4
`endif
) (
    input  logic          dir,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic [W-1:0]  first,
    output logic [W-1:0]  second,
`ifdef SORTER_INDEX_EN
    input  logic [TW-1:0] a_tag,
    input  logic [TW-1:0] b_tag,
    output logic [TW-1:0] first_tag,
    output logic [TW-1:0] second_tag,
`endif
    output logic          swap
);

    // Strict comparison only, so equal values keep their order (stable).
    assign swap   = (dir == SORT_ASC) ? (a > b) : (a < b);
    assign first  = swap ? b : a;
    assign second = swap ? a : b;

`ifdef SORTER_INDEX_EN
    assign first_tag  = swap ? b_tag : a_tag;
    assign second_tag = swap ? a_tag : b_tag;
`endif

endmodule

// File: rtl/odd_even_sorter.sv
// Handshaked odd-even transposition sorter, one phase per clock, early exit.
// Optional SORTER_INDEX_EN adds per-element origin tags and the IndexOut port.
module odd_even_sorter
    import sorter_pkg::*;
#(
    parameter int  N  = 16,
    parameter int  W  = 8,
    localparam int CW = calc_cw(N)
`ifdef SORTER_INDEX_EN
    ,
    localparam int IW = $clog2(N)
`endif
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            In_Valid,
    output logic            In_Ready,
    input  logic [N*W-1:0]  DataIn,
    input  logic            Dir,
    output logic            Out_Valid,
    input  logic            Out_Ready,
    output logic [N*W-1:0]  DataOut,
    output logic [CW-1:0]   Cambios,
`ifdef SORTER_INDEX_EN
    output logic [N*IW-1:0] IndexOut,
`endif
    output logic            listo
);

    localparam int NE = N / 2;
    localparam int NO = (N - 1) / 2;
    localparam int SW = $clog2(NE + 1);
    localparam int PW = $clog2(N);

    sort_state_t   state;
    logic          in_ready_reg;
    logic          out_valid_reg;
    logic          dir_reg;
    logic          zero_reg;
    logic [PW-1:0] phase_reg;
    logic [CW-1:0] cambios_reg;
    logic [CW-1:0] cambios_next;
    logic [CW:0]   cambios_sum;
    logic [SW-1:0] phase_swaps;
    logic          sort_exit;
    logic [N*W-1:0] data_out_reg;

    logic [W-1:0]  data_reg   [N];
    logic [W-1:0]  even_data  [N];
    logic [W-1:0]  odd_data   [N];
    logic [W-1:0]  phase_data [N];
    logic [NE-1:0] even_swap;
    logic [NE-1:0] odd_swap;

`ifdef SORTER_INDEX_EN
    logic [IW-1:0]   tag_reg   [N];
    logic [IW-1:0]   even_tag  [N];
    logic [IW-1:0]   odd_tag   [N];
    logic [IW-1:0]   phase_tag [N];
    logic [N*IW-1:0] index_out_reg;
`endif

    // Even bank: pairs (0,1),(2,3),...; an odd-N tail passes straight through.
    for (genvar gi = 0; gi < NE; gi++) begin : g_even
        cmp_swap #(
            .W(W)
`ifdef SORTER_INDEX_EN
            ,
            .TW(IW)
`endif
        ) u_cmp (
            .dir   (dir_reg),
            .a     (data_reg[2*gi]),
            .b     (data_reg[2*gi+1]),
            .first (even_data[2*gi]),
            .second(even_data[2*gi+1]),
`ifdef SORTER_INDEX_EN
            .a_tag     (tag_reg[2*gi]),
            .b_tag     (tag_reg[2*gi+1]),
            .first_tag (even_tag[2*gi]),
            .second_tag(even_tag[2*gi+1]),
`endif
            .swap  (even_swap[gi])
        );
    end
    if (N % 2 == 1) begin : g_even_tail
        assign even_data[N-1] = data_reg[N-1];
`ifdef SORTER_INDEX_EN
        assign even_tag[N-1] = tag_reg[N-1];
`endif
    end

    // Odd bank: pairs (1,2),(3,4),...; element 0 and an even-N tail pass through.
    for (genvar gi = 0; gi < NE; gi++) begin : g_odd
        if (gi < NO) begin : g_pair
            cmp_swap #(
                .W(W)
`ifdef SORTER_INDEX_EN
                ,
                .TW(IW)
`endif
            ) u_cmp (
                .dir   (dir_reg),
                .a     (data_reg[2*gi+1]),
                .b     (data_reg[2*gi+2]),
                .first (odd_data[2*gi+1]),
                .second(odd_data[2*gi+2]),
`ifdef SORTER_INDEX_EN
                .a_tag     (tag_reg[2*gi+1]),
                .b_tag     (tag_reg[2*gi+2]),
                .first_tag (odd_tag[2*gi+1]),
                .second_tag(odd_tag[2*gi+2]),
`endif
                .swap  (odd_swap[gi])
            );
        end else begin : g_none
            assign odd_swap[gi] = 1'b0;
        end
    end
    assign odd_data[0] = data_reg[0];
`ifdef SORTER_INDEX_EN
    assign odd_tag[0] = tag_reg[0];
`endif
    if (N % 2 == 0) begin : g_odd_tail
        assign odd_data[N-1] = data_reg[N-1];
`ifdef SORTER_INDEX_EN
        assign odd_tag[N-1] = tag_reg[N-1];
`endif
    end

    always_comb begin
        phase_swaps = '0;
        for (int k = 0; k < NE; k++) begin
            phase_swaps = phase_swaps + SW'(phase_reg[0] ? odd_swap[k] : even_swap[k]);
        end
        for (int k = 0; k < N; k++) begin
            phase_data[k] = phase_reg[0] ? odd_data[k] : even_data[k];
`ifdef SORTER_INDEX_EN
            phase_tag[k] = phase_reg[0] ? odd_tag[k] : even_tag[k];
`endif
        end
        cambios_sum  = {1'b0, cambios_reg} + (CW+1)'(phase_swaps);
        cambios_next = cambios_sum[CW] ? '1 : cambios_sum[CW-1:0];
        // Stop after two quiet phases in a row, or after the N-th phase.
        sort_exit = ((phase_swaps == '0) && zero_reg) || (phase_reg == PW'(N - 1));
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= IDLE;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            dir_reg       <= SORT_ASC;
            zero_reg      <= 1'b0;
            phase_reg     <= '0;
            cambios_reg   <= '0;
            data_out_reg  <= '0;
            for (int k = 0; k < N; k++) data_reg[k] <= '0;
`ifdef SORTER_INDEX_EN
            index_out_reg <= '0;
            for (int k = 0; k < N; k++) tag_reg[k] <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (In_Valid && in_ready_reg) begin
                        in_ready_reg <= 1'b0;
                        dir_reg      <= Dir;
                        zero_reg     <= 1'b0;
                        phase_reg    <= '0;
                        cambios_reg  <= '0;
                        for (int k = 0; k < N; k++) data_reg[k] <= DataIn[k*W +: W];
`ifdef SORTER_INDEX_EN
                        for (int k = 0; k < N; k++) tag_reg[k] <= IW'(k);
`endif
                        state <= SORT;
                    end else begin
                        in_ready_reg <= 1'b1;
                    end
                end
                SORT: begin
                    for (int k = 0; k < N; k++) data_reg[k] <= phase_data[k];
`ifdef SORTER_INDEX_EN
                    for (int k = 0; k < N; k++) tag_reg[k] <= phase_tag[k];
`endif
                    cambios_reg <= cambios_next;
                    zero_reg    <= (phase_swaps == '0);
                    phase_reg   <= phase_reg + 1'b1;
                    if (sort_exit) begin
                        for (int k = 0; k < N; k++) data_out_reg[k*W +: W] <= phase_data[k];
`ifdef SORTER_INDEX_EN
                        for (int k = 0; k < N; k++) index_out_reg[k*IW +: IW] <= phase_tag[k];
`endif
                        out_valid_reg <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (Out_Ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign In_Ready  = in_ready_reg;
    assign Out_Valid = out_valid_reg;
    assign DataOut   = data_out_reg;
    assign Cambios   = cambios_reg;
    assign listo     = out_valid_reg && Out_Ready;
`ifdef SORTER_INDEX_EN
    assign IndexOut  = index_out_reg;
`endif

endmodule
